// File: rtl/mem_arbiter_mc_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_arbiter_mc_pkg;

  localparam int         LEN_W     = 3;
  localparam logic       MEM_READ  = 1'b0;
  localparam logic       MEM_WRITE = 1'b1;
  localparam logic [1:0] IO_HI_DEF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2,
    ST_GAP  = 2'd3
  } mc_state_e;

  // Attributes of the transaction in flight, latched on grant.
  typedef struct packed {
    logic             wr;
    logic             sgn;
    logic [LEN_W-1:0] len;
  } xact_t;

  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_mc_if.sv
// Requester and RAM/IO bus bundle; slave = controller side, master = environment side.
interface mem_arbiter_mc_if
  import mem_arbiter_mc_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) ();

  logic [7:0]                        mem_din;
  logic [7:0]                        mem_dout;
  logic [ADDR_W-1:0]                 mem_addr;
  logic                              mem_wr;
  logic                              io_buffer_full;
  logic [NUM_PORTS-1:0]              req_en;
  logic [NUM_PORTS-1:0]              req_wr;
  logic [NUM_PORTS-1:0]              req_signed;
  logic [NUM_PORTS-1:0][LEN_W-1:0]   req_len;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_wdata;
  logic [NUM_PORTS-1:0]              done;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata;

  modport slave (
    input  mem_din, io_buffer_full, req_en, req_wr, req_signed, req_len, req_addr, req_wdata,
    output mem_dout, mem_addr, mem_wr, done, rdata
  );

  modport master (
    output mem_din, io_buffer_full, req_en, req_wr, req_signed, req_len, req_addr, req_wdata,
    input  mem_dout, mem_addr, mem_wr, done, rdata
  );

endinterface

// File: rtl/mem_arbiter_mc_rr_arbiter.sv
// Round-robin grant: first unmasked requester at or after ptr, circularly.
module mc_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic          gnt_vld,
  output logic [PW-1:0] gnt_idx
);

  logic [N-1:0]  elig;
  logic [PW-1:0] cand;

  assign elig = req & ~mask;

  // Scan farthest-to-nearest so the nearest eligible port wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = N-1; i >= 0; i--) begin
      cand = PW'((int'(ptr) + i) % N);
      if (elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_mc.sv
// Round-robin, byte-serial memory controller: N requesters onto one 8-bit RAM/UART bus,
// with sign extension, per-port flush and UART back-pressure.
module mem_arbiter_mc
  import mem_arbiter_mc_pkg::*;
#(
  parameter int                   NUM_PORTS  = 2,
  parameter int                   ADDR_W     = 32,
  parameter int                   MAX_BYTES  = 4,
  parameter logic [1:0]           IO_HI      = IO_HI_DEF,
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK = NUM_PORTS'(2'b10)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy,
  input  logic            clr,
  mem_arbiter_mc_if.slave bus
);

  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int PW     = port_w(NUM_PORTS);
  localparam int KW     = LEN_W + 1;

  mc_state_e            state_q, state_n;
  xact_t                cur_q;
  logic [PW-1:0]        port_q, rr_ptr_q;
  logic [KW-1:0]        k_q, k_n;
  logic                 replay_q, replay_n;
  logic [DATA_W-1:0]    asm_q, ld_val, cur_wsh;
  logic [ADDR_W-1:0]    cur_addr;
  logic [NUM_PORTS-1:0] io_hit, io_blk;
  logic                 gnt_vld, grant, cap, fin, stall, flush;
  logic [PW-1:0]        gnt_idx;
  logic [LEN_W-1:0]     gnt_len;

  always_comb begin
    io_hit = '0;
    io_blk = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      io_hit[p] = (bus.req_addr[p][17:16] == IO_HI);
      io_blk[p] = bus.req_wr[p] & io_hit[p] & bus.io_buffer_full;
    end
  end

  mc_rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
    .req     (bus.req_en),
    .mask    (io_blk),
    .ptr     (rr_ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // rst_n gates the grant so the bus stays idle while reset is held.
  assign grant   = (state_q == ST_IDLE) & rdy & ~clr & rst_n & gnt_vld;
  assign gnt_len = (bus.req_len[gnt_idx] > LEN_W'(MAX_BYTES-1)) ? LEN_W'(MAX_BYTES-1)
                                                                : bus.req_len[gnt_idx];

  // Requester holds addr/wdata until done, so they are read live rather than latched.
  assign cur_addr = bus.req_addr[port_q];
  assign cur_wsh  = bus.req_wdata[port_q] >> {k_q, 3'b000};
  assign stall    = cur_q.wr & io_hit[port_q] & bus.io_buffer_full;
  assign flush    = clr & (cur_q.wr == MEM_READ) & FLUSH_MASK[port_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      replay_q <= 1'b0;
      port_q   <= '0;
      cur_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_n;
      k_q      <= k_n;
      replay_q <= replay_n;
      if (grant) begin
        port_q   <= gnt_idx;
        cur_q    <= '{wr: bus.req_wr[gnt_idx], sgn: bus.req_signed[gnt_idx], len: gnt_len};
        rr_ptr_q <= (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // k = index of the byte being addressed; mem_din carries byte k-1.
  // A load that loses a cycle to rdy=0 replays address k-1 before moving on.
  always_comb begin
    state_n      = state_q;
    k_n          = k_q;
    replay_n     = replay_q;
    cap          = 1'b0;
    fin          = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          bus.mem_addr = bus.req_addr[gnt_idx];
          bus.mem_wr   = bus.req_wr[gnt_idx];
          if (bus.req_wr[gnt_idx] == MEM_WRITE) bus.mem_dout = bus.req_wdata[gnt_idx][7:0];
          k_n      = KW'(1);
          replay_n = 1'b0;
          state_n  = (gnt_len == '0) ? ST_LAST : ST_RUN;
        end
      end
      ST_RUN, ST_LAST: begin
        if (!rdy) begin
          replay_n = replay_q | ~cur_q.wr;
        end else if (flush) begin
          state_n  = ST_IDLE;
          replay_n = 1'b0;
        end else if (replay_q) begin
          bus.mem_addr = cur_addr + ADDR_W'(k_q - 1'b1);
          replay_n     = 1'b0;
        end else if (state_q == ST_LAST) begin
          fin     = 1'b1;
          state_n = ST_GAP;
        end else if (!stall) begin
          bus.mem_addr = cur_addr + ADDR_W'(k_q);
          bus.mem_wr   = cur_q.wr;
          if (cur_q.wr == MEM_WRITE) bus.mem_dout = cur_wsh[7:0];
          cap = ~cur_q.wr;
          k_n = k_q + 1'b1;
          if (k_q == {1'b0, cur_q.len}) state_n = ST_LAST;
        end
      end
      ST_GAP: begin
        if (rdy) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Final byte comes straight from mem_din; bytes above it are zero/sign fill.
  always_comb begin
    ld_val = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (LEN_W'(b) < cur_q.len)       ld_val[8*b +: 8] = asm_q[8*b +: 8];
      else if (LEN_W'(b) == cur_q.len) ld_val[8*b +: 8] = bus.mem_din;
      else                             ld_val[8*b +: 8] = {8{cur_q.sgn & bus.mem_din[7]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= '0;
      bus.done  <= '0;
      bus.rdata <= '0;
    end else begin
      bus.done <= '0;
      if (cap) begin
        for (int b = 0; b < MAX_BYTES; b++)
          if (k_q == KW'(b+1)) asm_q[8*b +: 8] <= bus.mem_din;
      end
      if (fin) begin
        bus.done[port_q] <= 1'b1;
        if (cur_q.wr == MEM_READ) bus.rdata[port_q] <= ld_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_mc.sv
// Directed bench for mem_arbiter_mc: loads, stores, RR order, UART stall, flush, rdy, reset.
module tb_mem_arbiter_mc;
  import mem_arbiter_mc_pkg::*;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;
  logic [7:0] ram [0:262143];

  mem_arbiter_mc_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter_mc #(
    .NUM_PORTS(NP), .ADDR_W(AW), .MAX_BYTES(4), .IO_HI(2'b11), .FLUSH_MASK(2'b10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_addr[17:0]];
    if (bus.mem_wr) ram[bus.mem_addr[17:0]] <= bus.mem_dout;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic wr, input logic sg, input logic [2:0] len,
                         input logic [31:0] a, input logic [31:0] wd);
    bus.req_wr[p]     = wr;
    bus.req_signed[p] = sg;
    bus.req_len[p]    = len;
    bus.req_addr[p]   = a;
    bus.req_wdata[p]  = wd;
    bus.req_en[p]     = 1'b1;
  endtask

  // Starts in IDLE; returns cycles from grant cycle to done cycle, ends back in IDLE.
  task automatic xact(input int p, input logic wr, input logic sg, input logic [2:0] len,
                      input logic [31:0] a, input logic [31:0] wd, output int c);
    set_req(p, wr, sg, len, a, wd);
    c = 0;
    do begin
      step();
      c++;
    end while (!bus.done[p] && c < 40);
    bus.req_en[p] = 1'b0;
    step();
  endtask

  initial begin
    logic [1:0] exp_done;
    logic [7:0] exp_dout [9];
    logic       exp_wr   [9];

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h20]  = 8'h80;
    ram[32'h50]  = 8'h34; ram[32'h51]  = 8'h92;
    ram[32'h40]  = 8'hDE; ram[32'h41]  = 8'hAD; ram[32'h42]  = 8'hBE; ram[32'h43]  = 8'hEF;
    bus.req_en = '0; bus.req_wr = '0; bus.req_signed = '0; bus.req_len = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.io_buffer_full = 1'b0;

    // Reset state
    step(); step();
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wr", bus.mem_wr, 0);
    chk("rst_dout", bus.mem_dout, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst_n = 1'b1;
    step();

    // 1: port0 LW 0x100, byte addresses on consecutive cycles
    set_req(0, 1'b0, 1'b0, 3'd3, 32'h100, 32'h0);
    #1 chk("t1_a0", bus.mem_addr, 32'h100);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t1_ak", bus.mem_addr, 32'h100 + k);
      chk("t1_nodone", bus.done, 0);
    end
    step();
    chk("t1_last_idle", bus.mem_addr, 0);
    chk("t1_last_nodone", bus.done, 0);
    step();
    chk("t1_done", bus.done, 2'b01);
    chk("t1_rdata", bus.rdata[0], 32'h44332211);
    bus.req_en[0] = 1'b0;
    step();

    // 2: sign/zero extension on port1
    xact(1, 1'b0, 1'b1, 3'd0, 32'h20, 32'h0, cyc);
    chk("t2_lb_lat", cyc, 2);
    chk("t2_lb_s", bus.rdata[1], 32'hFFFFFF80);
    xact(1, 1'b0, 1'b0, 3'd0, 32'h20, 32'h0, cyc);
    chk("t2_lbu", bus.rdata[1], 32'h00000080);
    xact(1, 1'b0, 1'b1, 3'd1, 32'h50, 32'h0, cyc);
    chk("t2_lh_s", bus.rdata[1], 32'hFFFF9234);

    // 3: both ports continuously, grants alternate with one GAP per done
    set_req(0, 1'b0, 1'b0, 3'd0, 32'h100, 32'h0);
    set_req(1, 1'b0, 1'b0, 3'd0, 32'h20, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_done = (i % 3 == 2) ? (((i / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("t3_done_seq", bus.done, exp_done);
    end
    bus.req_en = '0;
    step();
    chk("t3_rdata0", bus.rdata[0], 32'h00000011);

    // 4: UART store with 3 stall cycles after byte 0
    exp_wr   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_dout = '{8'hD4, 8'h00, 8'h00, 8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h00, 8'h00};
    set_req(1, 1'b1, 1'b0, 3'd3, 32'h30000, 32'hA1B2C3D4);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      bus.io_buffer_full = (c >= 1 && c <= 3);
      #1;
      chk("t4_wr", bus.mem_wr, exp_wr[c]);
      chk("t4_dout", bus.mem_dout, exp_dout[c]);
      chk("t4_done", bus.done, (c == 8) ? 2'b10 : 2'b00);
      if (c == 4) chk("t4_addr", bus.mem_addr, 32'h30001);
    end
    bus.req_en[1] = 1'b0;
    step();

    // 5: flush on masked port1 load, then port0 granted; store ignores flush
    set_req(1, 1'b0, 1'b0, 3'd3, 32'h100, 32'h0);
    step();
    set_req(0, 1'b0, 1'b0, 3'd0, 32'h40, 32'h0);
    step();
    clr = 1'b1;
    #1 chk("t5_nodone_a", bus.done, 0);
    step();
    clr = 1'b0;
    #1 chk("t5_p0_grant", bus.mem_addr, 32'h40);
    chk("t5_nodone_b", bus.done, 0);
    bus.req_en[1] = 1'b0;
    step(); step();
    chk("t5_done0", bus.done, 2'b01);
    chk("t5_rdata0", bus.rdata[0], 32'h000000DE);
    chk("t5_rdata1_kept", bus.rdata[1], 32'h00000080);
    bus.req_en[0] = 1'b0;
    step();
    set_req(1, 1'b1, 1'b0, 3'd3, 32'h200, 32'h55667788);
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step(); step();
    chk("t5_st_done", bus.done, 2'b10);
    bus.req_en[1] = 1'b0;
    step();
    chk("t5_st_ram", {ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]}, 32'h55667788);

    // 6: reset during RUN; port0 first afterwards
    set_req(1, 1'b0, 1'b0, 3'd3, 32'h100, 32'h0);
    step(); step();
    set_req(0, 1'b0, 1'b0, 3'd3, 32'h40, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_addr", bus.mem_addr, 0);
    chk("t6_wr", bus.mem_wr, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_rdata", bus.rdata, 0);
    step();
    rst_n = 1'b1;
    #1 chk("t6_p0_first", bus.mem_addr, 32'h40);
    bus.req_en[1] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t6_nodone", bus.done, 0);
    end
    step();
    chk("t6_done0", bus.done, 2'b01);
    chk("t6_rdata0", bus.rdata[0], 32'hEFBEADDE);
    bus.req_en[0] = 1'b0;
    step();

    // 7: rdy low mid-load; byte address replayed
    set_req(0, 1'b0, 1'b0, 3'd3, 32'h100, 32'h0);
    step(); step();
    rdy = 1'b0;
    #1 chk("t7_idle_bus", bus.mem_addr, 0);
    step(); step();
    rdy = 1'b1;
    #1 chk("t7_replay", bus.mem_addr, 32'h101);
    step();
    chk("t7_resume", bus.mem_addr, 32'h102);
    step(); step(); step();
    chk("t7_done", bus.done, 2'b01);
    chk("t7_rdata", bus.rdata[0], 32'h44332211);
    bus.req_en[0] = 1'b0;
    step();

    // 8: req_len above MAX_BYTES-1 clamps to a 4-byte load
    xact(0, 1'b0, 1'b0, 3'd7, 32'h40, 32'h0, cyc);
    chk("t8_lat", cyc, 5);
    chk("t8_rdata", bus.rdata[0], 32'hEFBEADDE);

    // 9: UART-blocked store skipped in IDLE, granted once buffer drains
    bus.io_buffer_full = 1'b1;
    set_req(1, 1'b1, 1'b0, 3'd0, 32'h30010, 32'h5A);
    set_req(0, 1'b0, 1'b0, 3'd0, 32'h20, 32'h0);
    #1 chk("t9_skip", bus.mem_addr, 32'h20);
    step();
    bus.io_buffer_full = 1'b0;
    step();
    chk("t9_done0", bus.done, 2'b01);
    bus.req_en[0] = 1'b0;
    step();
    chk("t9_st_wr", bus.mem_wr, 1);
    chk("t9_st_dout", bus.mem_dout, 8'h5A);
    step(); step();
    chk("t9_done1", bus.done, 2'b10);
    bus.req_en[1] = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
